// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped branch predictor / BTB with saturating counters
module branch_predictor #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_BITS  = 4,
    parameter int CTR_BITS    = 2,
    parameter int COUNT_WIDTH = 32,
    parameter int DYNAMIC     = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  IF_PC,
    output logic                   Pred_Taken,
    output logic [ADDR_WIDTH-1:0]  Pred_Target,
    input  logic                   EX_Valid,
    input  logic [ADDR_WIDTH-1:0]  EX_PC,
    input  logic                   EX_Taken,
    input  logic [ADDR_WIDTH-1:0]  EX_Target,
    input  logic                   EX_Pred_Taken,
    input  logic [ADDR_WIDTH-1:0]  EX_Pred_Target,
    output logic                   Mispredict,
    output logic [ADDR_WIDTH-1:0]  Redirect_PC,
    output logic [COUNT_WIDTH-1:0] Branch_Count,
    output logic [COUNT_WIDTH-1:0] Mispredict_Count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = ADDR_WIDTH - INDEX_BITS - 2;
    localparam bit DYN     = (DYNAMIC != 0);

    localparam logic [CTR_BITS-1:0]    CTR_MAX        = '1;
    localparam logic [CTR_BITS-1:0]    CTR_WEAK_TAKEN = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0]    CTR_RESET      = CTR_WEAK_TAKEN - CTR_BITS'(1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX      = '1;

    logic [ENTRIES-1:0]    valid_q;
    logic [TAG_W-1:0]      tag_q    [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
    logic [CTR_BITS-1:0]   ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] if_idx;
    logic [INDEX_BITS-1:0] ex_idx;
    logic [TAG_W-1:0]      if_tag;
    logic [TAG_W-1:0]      ex_tag;
    logic                  if_hit;
    logic                  ex_hit;
    logic                  unused_pc_bits;

    assign if_idx = IF_PC[INDEX_BITS+1:2];
    assign if_tag = IF_PC[ADDR_WIDTH-1:INDEX_BITS+2];
    assign ex_idx = EX_PC[INDEX_BITS+1:2];
    assign ex_tag = EX_PC[ADDR_WIDTH-1:INDEX_BITS+2];
    assign unused_pc_bits = ^{IF_PC[1:0], EX_PC[1:0]};

    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // Lookup reads only registered state, so a same-cycle update is not visible.
    assign Pred_Taken  = DYN && if_hit && ctr_q[if_idx][CTR_BITS-1];
    assign Pred_Target = Pred_Taken ? target_q[if_idx] : '0;

    assign Mispredict  = DYN ? (EX_Valid && ((EX_Taken != EX_Pred_Taken) ||
                                             (EX_Taken && (EX_Target != EX_Pred_Target))))
                             : (EX_Valid && EX_Taken);
    assign Redirect_PC = EX_Taken ? EX_Target : EX_PC + ADDR_WIDTH'(4);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else if (DYN && EX_Valid) begin
            if (ex_hit) begin
                if (EX_Taken) begin
                    if (ctr_q[ex_idx] != CTR_MAX) begin
                        ctr_q[ex_idx] <= ctr_q[ex_idx] + CTR_BITS'(1);
                    end
                    target_q[ex_idx] <= EX_Target;
                end else if (ctr_q[ex_idx] != '0) begin
                    ctr_q[ex_idx] <= ctr_q[ex_idx] - CTR_BITS'(1);
                end
            end else if (EX_Taken) begin
                // Allocation evicts whatever alias currently owns the slot.
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= EX_Target;
                ctr_q[ex_idx]    <= CTR_WEAK_TAKEN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Branch_Count     <= '0;
            Mispredict_Count <= '0;
        end else begin
            if (EX_Valid && (Branch_Count != COUNT_MAX)) begin
                Branch_Count <= Branch_Count + COUNT_WIDTH'(1);
            end
            if (Mispredict && (Mispredict_Count != COUNT_MAX)) begin
                Mispredict_Count <= Mispredict_Count + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor and branch target buffer for the next-generation five-stage pipeline. It replaces static predict-not-taken with a direct-mapped table of tags, targets and saturating counters, looked up from the IF-stage PC. The table is trained from resolved branches and jumps in EX. When the resolution disagrees with the prediction, the block produces the misprediction flag and the corrected PC. It also keeps branch and mispredict statistics counters.

## Interface
Parameters:
- ADDR_WIDTH, 32, PC width.
- INDEX_BITS, 4, table has 2^INDEX_BITS entries.
- CTR_BITS, 2, saturating counter width (≥1).
- COUNT_WIDTH, 32, statistics counter width.
- DYNAMIC, 1, 1 = table prediction; 0 = static not-taken, table never written.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- IF_PC  in  ADDR_WIDTH  PC being fetched.
- Pred_Taken  out  1  predict taken for IF_PC.
- Pred_Target  out  ADDR_WIDTH  predicted target; 0 when Pred_Taken=0.
- EX_Valid  in  1  EX holds a real (unflushed) branch/jump this cycle.
- EX_PC  in  ADDR_WIDTH  address of that instruction.
- EX_Taken  in  1  resolved direction (jumps: 1).
- EX_Target  in  ADDR_WIDTH  resolved taken target.
- EX_Pred_Taken  in  1  prediction carried down the pipeline with the instruction.
- EX_Pred_Target  in  ADDR_WIDTH  predicted target carried down the pipeline.
- Mispredict  out  1  flush IF/ID and ID/EX, redirect PC.
- Redirect_PC  out  ADDR_WIDTH  correct next PC.
- Branch_Count  out  COUNT_WIDTH  resolved EX_Valid events.
- Mispredict_Count  out  COUNT_WIDTH  mispredict events.

## Operation
- Addressing: index = PC[INDEX_BITS+1:2]; tag = PC[ADDR_WIDTH-1:INDEX_BITS+2]. PC[1:0] is ignored.
- Entry contents: valid, tag, target, counter.
- Lookup (combinational from registered table): hit = valid && tag match.
  - Pred_Taken = DYNAMIC && hit && counter MSB.
  - Pred_Target = entry target when Pred_Taken, else 0.
- Mispredict = EX_Valid && (EX_Taken != EX_Pred_Taken || (EX_Taken && EX_Target != EX_Pred_Target)).
- Redirect_PC = EX_Taken ? EX_Target : EX_PC+4, with wrap modulo 2^ADDR_WIDTH. Redirect_PC is valid only while Mispredict=1.
- Update (DYNAMIC=1, EX_Valid=1), written at the clock edge:
  - Hit and taken: counter +1, saturating at all-ones; target ← EX_Target.
  - Hit and not taken: counter −1, saturating at 0; target unchanged.
  - Miss and taken: allocate, overwriting any alias. valid=1, tag, target=EX_Target, counter=2^(CTR_BITS-1) (weakly taken).
  - Miss and not taken: no write.
- Statistics, on the clock edge:
  - Branch_Count +1 per EX_Valid.
  - Mispredict_Count +1 per Mispredict.
  - Both saturate at all-ones; neither wraps.
- DYNAMIC=0: Pred_Taken=0, Pred_Target=0, no table writes; Mispredict = EX_Valid && EX_Taken.

## Timing
- Reset (synchronous): all valid bits clear, counters = 2^(CTR_BITS-1)-1, targets and tags 0, both statistics counters 0.
  - Outputs after reset: Pred_Taken=0, Pred_Target=0, Branch_Count=0, Mispredict_Count=0.
  - Mispredict and Redirect_PC remain combinational from the EX inputs.
- Reset asserted in the same cycle as EX_Valid: reset wins; no update, no count.
- Prediction latency is 0 cycles: outputs are combinational from IF_PC.
- Mispredict and Redirect_PC are combinational in the cycle the branch is in EX.
- An update becomes visible to lookup the cycle after EX_Valid. There is no write-to-read bypass: a same-cycle lookup of the index being updated sees the old entry.
- One update per cycle maximum. The block has no stall input; the pipeline holds EX_Valid low during bubbles and flushes.
- The table uses plain registers (no RAM inference requirement), so reset clears every entry in one cycle.

## Test plan
Defaults: INDEX_BITS=4, CTR_BITS=2.
- **Reset:** pulse reset, IF_PC=0x00000040 -> Pred_Taken=0, Pred_Target=0, Branch_Count=0, Mispredict_Count=0.
- **Allocate on taken:** EX_Valid=1, EX_PC=0x40, EX_Taken=1, EX_Target=0x100, EX_Pred_Taken=0 -> Mispredict=1, Redirect_PC=0x100 that cycle. Next cycle IF_PC=0x40 -> Pred_Taken=1, Pred_Target=0x100. Counts = 1/1.
- **Hysteresis and saturation:** three more taken updates for 0x40 (counter saturates at 3), then one not-taken -> Pred_Taken stays 1. A second not-taken -> Pred_Taken=0. Each not-taken with EX_Pred_Taken=1 gives Mispredict=1, Redirect_PC=0x44.
- **Aliasing and target change:** taken update EX_PC=0x80 (same index 0, different tag), EX_Target=0x200 -> lookup 0x40 misses (Pred_Taken=0) and lookup 0x80 gives 0x200. Then a taken update for 0x80 with EX_Target=0x300 and EX_Pred_Target=0x200 -> Mispredict=1, new Pred_Target=0x300.
- **Same-cycle edge cases:**
  - Update 0x40 while IF_PC=0x40 -> Pred_Target shows the pre-update value that cycle.
  - Reset with EX_Valid=1 -> table clear and counts 0 next cycle.
  - EX_PC=0xFFFFFFFC, EX_Taken=0 -> Redirect_PC=0x00000000.
- **Static mode (DYNAMIC=0):** 0x40 taken twice -> Pred_Taken always 0, Mispredict=1 both times, Mispredict_Count=2. Preload counters near all-ones with COUNT_WIDTH=4 -> saturation at 15.
